// File: rtl/rvr32_hostmbox_if.sv
// rtl/rvr32_hostmbox_if.sv - rvr32 bus responder and host stream signals for the host mailbox
interface rvr32_hostmbox_if;
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        host_in_valid;
    logic [31:0] host_in_data;
    logic        host_in_ready;
    logic        host_out_valid;
    logic [31:0] host_out_data;
    logic        host_out_ready;
    logic        irq;

    modport slave (
        input  valid, addr, wstrb, wdata, host_in_valid, host_in_data, host_out_ready,
        output ready, rdata, host_in_ready, host_out_valid, host_out_data, irq
    );

    modport master (
        output valid, addr, wstrb, wdata, host_in_valid, host_in_data, host_out_ready,
        input  ready, rdata, host_in_ready, host_out_valid, host_out_data, irq
    );
endinterface

// File: rtl/rvr32_hostmbox.sv
// rtl/rvr32_hostmbox.sv - host mailbox: rvr32 bus responder with RX/TX word FIFOs and wait-state FSM
module rvr32_hostmbox #(
    parameter int DEPTH = 8,
    parameter int WAIT  = 1
) (
    input  logic             clk_2x,
    input  logic             rst_n,
    rvr32_hostmbox_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [31:0] ID_VALUE = 32'h4D42_0001;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] resp_q, rdata_q, rd_val;

    logic [31:0] rx_mem [DEPTH];
    logic [31:0] tx_mem [DEPTH];
    logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic [AW:0]   rx_cnt, tx_cnt;
    logic          err_ovf, err_udf, ie_q;

    logic        accept, is_write, sel_data, ctrl_wr, flush, err_clr;
    logic        rx_empty, rx_full, tx_empty, tx_full;
    logic        bus_rx_pop, bus_tx_push, udf_set, ovf_set, host_rx_push, host_tx_pop;
    logic [31:0] push_word;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{bus.addr[31:4], bus.addr[1:0]};

    assign accept   = (state_q == S_IDLE) && bus.valid;
    assign is_write = |bus.wstrb;
    assign sel_data = (bus.addr[3:2] == 2'd0);
    assign ctrl_wr  = accept && is_write && (bus.addr[3:2] == 2'd2) && bus.wstrb[0];
    assign flush    = ctrl_wr && bus.wdata[0];
    assign err_clr  = ctrl_wr && bus.wdata[1];

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == FULL_CNT);

    assign bus_rx_pop   = accept && !is_write && sel_data && !rx_empty;
    assign udf_set      = accept && !is_write && sel_data && rx_empty;
    assign bus_tx_push  = accept && is_write && sel_data && !tx_full;
    assign ovf_set      = accept && is_write && sel_data && tx_full;
    assign host_rx_push = bus.host_in_valid && !rx_full;
    assign host_tx_pop  = bus.host_out_ready && !tx_empty;

    // Disabled byte lanes are pushed as zero, not left as stale data.
    assign push_word = {bus.wstrb[3] ? bus.wdata[31:24] : 8'h00,
                        bus.wstrb[2] ? bus.wdata[23:16] : 8'h00,
                        bus.wstrb[1] ? bus.wdata[15:8]  : 8'h00,
                        bus.wstrb[0] ? bus.wdata[7:0]   : 8'h00};

    always_comb begin
        rd_val = '0;
        if (!is_write) begin
            case (bus.addr[3:2])
                2'd0: rd_val = rx_empty ? 32'h0 : rx_mem[rx_rp];
                2'd1: rd_val = {6'b0, err_udf, err_ovf, 6'b0, tx_full, rx_empty,
                                8'(tx_cnt), 8'(rx_cnt)};
                2'd2: rd_val = {29'b0, ie_q, 2'b0};
                default: rd_val = ID_VALUE;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: if (bus.valid) begin
                wcnt_d  = 4'(WAIT);
                state_d = (WAIT > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_2x or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            resp_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (accept) resp_q <= rd_val;
            // With WAIT=0 the response register is bypassed on the acceptance edge.
            if (state_d == S_RESP && state_q != S_RESP)
                rdata_q <= (state_q == S_IDLE) ? rd_val : resp_q;
        end
    end

    always_ff @(posedge clk_2x or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
            tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
            err_ovf <= 1'b0; err_udf <= 1'b0; ie_q <= 1'b0;
        end else begin
            if (flush) begin
                rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
                tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
            end else begin
                if (host_rx_push) rx_wp <= rx_wp + 1'b1;
                if (bus_rx_pop)   rx_rp <= rx_rp + 1'b1;
                if (host_rx_push && !bus_rx_pop)      rx_cnt <= rx_cnt + 1'b1;
                else if (!host_rx_push && bus_rx_pop) rx_cnt <= rx_cnt - 1'b1;
                if (bus_tx_push) tx_wp <= tx_wp + 1'b1;
                if (host_tx_pop) tx_rp <= tx_rp + 1'b1;
                if (bus_tx_push && !host_tx_pop)      tx_cnt <= tx_cnt + 1'b1;
                else if (!bus_tx_push && host_tx_pop) tx_cnt <= tx_cnt - 1'b1;
            end
            if (err_clr)      err_ovf <= 1'b0;
            else if (ovf_set) err_ovf <= 1'b1;
            if (err_clr)      err_udf <= 1'b0;
            else if (udf_set) err_udf <= 1'b1;
            if (ctrl_wr) ie_q <= bus.wdata[2];
        end
    end

    always_ff @(posedge clk_2x) begin
        if (host_rx_push) rx_mem[rx_wp] <= bus.host_in_data;
        if (bus_tx_push)  tx_mem[tx_wp] <= push_word;
    end

    assign bus.ready          = (state_q == S_RESP);
    assign bus.rdata          = rdata_q;
    assign bus.host_in_ready  = !rx_full;
    assign bus.host_out_valid = !tx_empty;
    assign bus.host_out_data  = tx_empty ? 32'h0 : tx_mem[tx_rp];
    assign bus.irq            = ie_q && !rx_empty;
endmodule

// File: tb/tb_rvr32_hostmbox.sv
// tb/tb_rvr32_hostmbox.sv - self-checking bench for rvr32_hostmbox with a queue-based mailbox model
module tb_rvr32_hostmbox;
    localparam int D  = 8;
    localparam int W  = 1;
    localparam int W5 = 5;
    localparam logic [31:0] ID_VALUE = 32'h4D42_0001;

    logic clk_2x = 1'b0;
    logic rst_n  = 1'b0;
    logic rst5_n = 1'b0;
    always #5 clk_2x = ~clk_2x;

    rvr32_hostmbox_if mb();
    rvr32_hostmbox_if mb5();

    rvr32_hostmbox #(.DEPTH(D), .WAIT(W)) dut (
        .clk_2x(clk_2x), .rst_n(rst_n), .bus(mb.slave)
    );
    rvr32_hostmbox #(.DEPTH(D), .WAIT(W5)) dut5 (
        .clk_2x(clk_2x), .rst_n(rst5_n), .bus(mb5.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (!s[b]) d[8*b +: 8] = 8'h00;
        return d;
    endfunction

    // Model: mailbox contents as queues, response timing as edges since acceptance.
    logic [31:0] m_rx[$];
    logic [31:0] m_tx[$];
    bit          m_ovf, m_udf, m_ie, m_active, exp_ready, rd_chk, pend_rd, hpush, hpop, m_flush;
    int          m_t, rx_n, tx_n;
    logic [31:0] pend, exp_rdata;

    always @(posedge clk_2x) begin
        if (!rst_n) begin
            m_rx.delete(); m_tx.delete();
            m_ovf = 0; m_udf = 0; m_ie = 0; m_active = 0; exp_ready = 0; rd_chk = 0;
        end else begin
            rx_n = m_rx.size();
            tx_n = m_tx.size();
            hpush = mb.host_in_valid && (rx_n < D);
            hpop  = mb.host_out_ready && (tx_n > 0);
            m_flush = 0;
            if (m_active) begin
                m_t++;
                if (m_t > W) m_active = 0;
            end else if (mb.valid) begin
                m_active = 1;
                m_t = 0;
                pend = '0;
                pend_rd = (mb.wstrb == 4'b0);
                case (mb.addr[3:2])
                    2'd0: if (pend_rd) begin
                              if (rx_n > 0) pend = m_rx.pop_front();
                              else m_udf = 1;
                          end else begin
                              if (tx_n < D) m_tx.push_back(lane_mask(mb.wdata, mb.wstrb));
                              else m_ovf = 1;
                          end
                    2'd1: pend = {6'b0, m_udf, m_ovf, 6'b0, tx_n == D, rx_n == 0, 8'(tx_n), 8'(rx_n)};
                    2'd2: if (pend_rd) pend = {29'b0, m_ie, 2'b0};
                          else if (mb.wstrb[0]) begin
                              if (mb.wdata[1]) begin m_ovf = 0; m_udf = 0; end
                              m_ie = mb.wdata[2];
                              m_flush = mb.wdata[0];
                          end
                    default: pend = ID_VALUE;
                endcase
            end
            if (hpop) void'(m_tx.pop_front());
            if (hpush) m_rx.push_back(mb.host_in_data);
            if (m_flush) begin m_rx.delete(); m_tx.delete(); end
            exp_ready = m_active && (m_t == W);
            if (exp_ready) begin exp_rdata = pend; rd_chk = pend_rd; end
        end
    end

    always @(negedge clk_2x) begin
        if (rst_n) begin
            chk("ready", mb.ready, exp_ready);
            if (exp_ready && rd_chk) chk("rdata", mb.rdata, exp_rdata);
            chk("host_in_ready", mb.host_in_ready, m_rx.size() < D);
            chk("host_out_valid", mb.host_out_valid, m_tx.size() > 0);
            chk("host_out_data", mb.host_out_data, (m_tx.size() > 0) ? m_tx[0] : 32'h0);
            chk("irq", mb.irq, m_ie && (m_rx.size() > 0));
        end
    end

    task automatic bus_op(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          input bit with_push, input logic [31:0] pw, output logic [31:0] rd);
        int n = 0;
        @(posedge clk_2x); #1;
        mb.valid = 1'b1; mb.addr = a; mb.wstrb = s; mb.wdata = d;
        if (with_push) begin mb.host_in_valid = 1'b1; mb.host_in_data = pw; end
        do begin
            @(negedge clk_2x);
            n++;
            if (n == 2) mb.host_in_valid = 1'b0;
        end while (!mb.ready && n < 40);
        chk("latency", n, W + 2);
        rd = mb.rdata;
        @(posedge clk_2x); #1;
        mb.valid = 1'b0;
    endtask

    task automatic bus5(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd);
        int n = 0;
        @(posedge clk_2x); #1;
        mb5.valid = 1'b1; mb5.addr = a; mb5.wstrb = s; mb5.wdata = d;
        do begin @(negedge clk_2x); n++; end while (!mb5.ready && n < 40);
        chk("latency5", n, W5 + 2);
        rd = mb5.rdata;
        @(posedge clk_2x); #1;
        mb5.valid = 1'b0;
    endtask

    task automatic host_push(input logic [31:0] d);
        @(posedge clk_2x); #1;
        mb.host_in_valid = 1'b1; mb.host_in_data = d;
        @(posedge clk_2x); #1;
        mb.host_in_valid = 1'b0;
    endtask

    task automatic host_pop();
        @(posedge clk_2x); #1;
        mb.host_out_ready = 1'b1;
        @(posedge clk_2x); #1;
        mb.host_out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int hits;
        mb.valid = 0; mb.addr = 0; mb.wstrb = 0; mb.wdata = 0;
        mb.host_in_valid = 0; mb.host_in_data = 0; mb.host_out_ready = 0;
        mb5.valid = 0; mb5.addr = 0; mb5.wstrb = 0; mb5.wdata = 0;
        mb5.host_in_valid = 0; mb5.host_in_data = 0; mb5.host_out_ready = 0;

        repeat (3) @(posedge clk_2x);
        @(negedge clk_2x);
        chk("rst_ready", mb.ready, 0);
        chk("rst_rdata", mb.rdata, 0);
        chk("rst_host_in_ready", mb.host_in_ready, 1);
        chk("rst_host_out_valid", mb.host_out_valid, 0);
        chk("rst_host_out_data", mb.host_out_data, 0);
        chk("rst_irq", mb.irq, 0);
        @(posedge clk_2x); #1;
        rst_n = 1'b1; rst5_n = 1'b1;

        host_push(32'hA5A5_0001);
        host_push(32'hA5A5_0002);
        bus_op(32'h0, 4'h0, 0, 0, 0, r); chk("rx_pop0", r, 32'hA5A5_0001);
        bus_op(32'h0, 4'h0, 0, 0, 0, r); chk("rx_pop1", r, 32'hA5A5_0002);
        bus_op(32'h4, 4'h0, 0, 0, 0, r); chk("status_idle", r, 32'h0001_0000);

        bus_op(32'h0, 4'b0101, 32'h1122_3344, 0, 0, r);
        @(negedge clk_2x);
        chk("lane_valid", mb.host_out_valid, 1);
        chk("lane_data", mb.host_out_data, 32'h0022_0044);
        host_pop();

        for (int i = 0; i < 9; i++) bus_op(32'h0, 4'hF, 32'hC0DE_0000 + i, 0, 0, r);
        bus_op(32'h4, 4'h0, 0, 0, 0, r); chk("status_full", r, 32'h0103_0800);
        bus_op(32'h8, 4'h1, 32'h2, 0, 0, r);
        bus_op(32'h4, 4'h0, 0, 0, 0, r); chk("status_clr", r, 32'h0003_0800);
        repeat (8) host_pop();

        bus_op(32'h0, 4'h0, 0, 1, 32'hDEAD_BEEF, r); chk("udf_rdata", r, 0);
        bus_op(32'h4, 4'h0, 0, 0, 0, r); chk("status_udf", r, 32'h0200_0001);
        bus_op(32'h0, 4'h0, 0, 0, 0, r); chk("udf_kept", r, 32'hDEAD_BEEF);
        bus_op(32'h8, 4'h1, 32'h2, 0, 0, r);

        bus_op(32'h8, 4'h1, 32'h4, 0, 0, r);
        host_push(32'h0000_0077);
        @(negedge clk_2x);
        chk("irq_set", mb.irq, 1);
        bus_op(32'hC, 4'h0, 0, 0, 0, r); chk("id", r, ID_VALUE);
        bus_op(32'h8, 4'h1, 32'h5, 1, 32'h0000_0088, r);
        @(negedge clk_2x);
        chk("irq_flushed", mb.irq, 0);
        bus_op(32'h8, 4'h0, 0, 0, 0, r); chk("ctrl_ie", r, 32'h4);
        bus_op(32'h4, 4'h0, 0, 0, 0, r); chk("status_flushed", r, 32'h0001_0000);

        bus5(32'h0, 4'hF, 32'h55, r);
        bus5(32'hC, 4'h0, 0, r); chk("id5", r, ID_VALUE);
        chk("tx5_valid", mb5.host_out_valid, 1);
        chk("tx5_data", mb5.host_out_data, 32'h55);
        @(posedge clk_2x); #1;
        mb5.valid = 1'b1; mb5.addr = 32'h4; mb5.wstrb = 4'h0;
        repeat (3) @(posedge clk_2x);
        #2 rst5_n = 1'b0;
        #1;
        chk("rst5_ready", mb5.ready, 0);
        chk("rst5_rdata", mb5.rdata, 0);
        chk("rst5_host_in_ready", mb5.host_in_ready, 1);
        chk("rst5_host_out_valid", mb5.host_out_valid, 0);
        chk("rst5_host_out_data", mb5.host_out_data, 0);
        chk("rst5_irq", mb5.irq, 0);
        @(posedge clk_2x); #1;
        mb5.valid = 1'b0;
        rst5_n = 1'b1;
        hits = 0;
        repeat (12) begin @(negedge clk_2x); if (mb5.ready) hits++; end
        chk("rst5_no_ready", hits, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
